free_list: RTL

Physical-register free list for the rename stage. It supplies the new_preg that the map table installs for each renamed destination. It takes back the old_p_dest of each committing instruction once the ROB retires it. Per-ROB-tag checkpoints of the allocation pointer let a branch mispredict return all speculatively allocated registers in one cycle, in lockstep with the map table's snapshot restore.

---
 rtl/free_list.sv | 117 +++++++++++
 1 files changed

// File: rtl/free_list.sv
// Physical-register free list for rename: circular buffer of free pregs
// with per-ROB-tag head checkpoints for one-cycle mispredict recovery.
`timescale 1ns/1ps
module free_list #(
   parameter int AREG_WIDTH = 5,
   parameter int PREG_WIDTH = 7,
   parameter int ROB_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alloc_req,
   output logic                  alloc_valid,
   output logic [PREG_WIDTH-1:0] alloc_preg,
   input  logic                  free_valid,
   input  logic [PREG_WIDTH-1:0] free_preg,
   input  logic                  is_branch_dispatch,
   input  logic [ROB_WIDTH-1:0]  dispatch_tag,
   input  logic                  branch_mispredict,
   input  logic [ROB_WIDTH-1:0]  recovery_tag,
   output logic [PREG_WIDTH-1:0] free_count
);

   localparam int NUM_AREGS     = 2 ** AREG_WIDTH;
   localparam int NUM_PREGS     = 2 ** PREG_WIDTH;
   localparam int NUM_SNAPSHOTS = 2 ** ROB_WIDTH;
   localparam int DEPTH         = NUM_PREGS - NUM_AREGS;
   localparam int IDX_W         = $clog2(DEPTH);
   localparam int PTR_W         = IDX_W + 1;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W:0]   DEPTH_CNT = PTR_W'(DEPTH);

   // Pointers are {lap, idx}; the lap bit disambiguates full from empty
   // because DEPTH is not a power of two.
   logic [PREG_WIDTH-1:0] entries   [DEPTH];
   logic [PTR_W-1:0]      snap_head [NUM_SNAPSHOTS];
   logic [PTR_W-1:0]      head;
   logic [PTR_W-1:0]      tail;
   logic [PTR_W-1:0]      head_adv;
   logic [PTR_W-1:0]      head_next;
   logic [IDX_W-1:0]      head_idx;
   logic [IDX_W-1:0]      tail_idx;
   logic                  empty;
   logic                  full;
   logic                  alloc_fire;
   logic                  free_fire;
   logic                  snap_fire;
   logic [IDX_W:0]        count;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p[IDX_W-1:0] == LAST_IDX)
         ptr_inc = {~p[IDX_W], {IDX_W{1'b0}}};
      else
         ptr_inc = {p[IDX_W], p[IDX_W-1:0] + 1'b1};
   endfunction

   assign head_idx = head[IDX_W-1:0];
   assign tail_idx = tail[IDX_W-1:0];
   assign empty    = (head == tail);
   assign full     = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);

   // A same-cycle allocation frees the head slot, so a free into a full
   // list is legal then; recovery cancels any allocation in its cycle.
   assign alloc_fire = alloc_req && !empty && !branch_mispredict;
   assign free_fire  = free_valid && (free_preg != '0) && (!full || alloc_fire);
   assign snap_fire  = is_branch_dispatch && !branch_mispredict;

   assign head_adv  = alloc_fire ? ptr_inc(head) : head;
   assign head_next = branch_mispredict ? snap_head[recovery_tag] : head_adv;

   // Occupancy from the two pointers, modulo DEPTH with full as a special case
   always_comb begin
      count = '0;
      if (full)
         count = DEPTH_CNT;
      else if (tail_idx >= head_idx)
         count = {1'b0, tail_idx} - {1'b0, head_idx};
      else
         count = {1'b0, tail_idx} + DEPTH_CNT - {1'b0, head_idx};
   end

   assign alloc_valid = !empty;
   assign alloc_preg  = entries[head_idx];
   assign free_count  = PREG_WIDTH'(count);

   // Head/tail pointers and buffer contents; reset refills with pregs above the arch set
   always_ff @(posedge clk) begin
      if (reset) begin
         head <= '0;
         tail <= {1'b1, {IDX_W{1'b0}}};
         for (int i = 0; i < DEPTH; i++)
            entries[i] <= PREG_WIDTH'(NUM_AREGS + i);
      end else begin
         head <= head_next;
         if (free_fire) begin
            entries[tail_idx] <= free_preg;
            tail              <= ptr_inc(tail);
         end
      end
   end

   // Checkpoint the post-allocation head so it lines up with the map snapshot
   always_ff @(posedge clk) begin
      if (!reset && snap_fire)
         snap_head[dispatch_tag] <= head_adv;
   end

   // Rename must stall on empty; commit must never overfill the list
   a_alloc_empty: assert property (@(posedge clk) disable iff (reset)
      !(alloc_req && !branch_mispredict && empty))
      else $warning("free_list: alloc_req while empty ignored");

   a_free_full: assert property (@(posedge clk) disable iff (reset)
      !(free_valid && (free_preg != '0) && full && !alloc_fire))
      else $warning("free_list: free while full dropped");

endmodule
